// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - byte-send handshake and serial line bundle for the UART transmitter
interface uart_tx_serializer_if;
    logic       tx_write;
    logic [7:0] tx_bus;
    logic       tx_done;
    logic       tx;
    logic       tx_busy;
    logic       tx_overrun;

    modport master (
        output tx_write,
        output tx_bus,
        input  tx_done,
        input  tx,
        input  tx_busy,
        input  tx_overrun
    );

    modport slave (
        input  tx_write,
        input  tx_bus,
        output tx_done,
        output tx,
        output tx_busy,
        output tx_overrun
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART frame serializer with a one-byte holding register
module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_serializer_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic        ODD       = (PARITY == 2);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_valid_q, hold_valid_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        overrun_q, overrun_d;

    logic        bit_end;
    logic        load;
    logic        idle_write;
    logic [7:0]  load_byte;

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        par_d        = par_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        done_d       = 1'b0;
        overrun_d    = overrun_q;
        load         = 1'b0;
        load_byte    = hold_q;
        bit_end      = (baud_q == BAUD_LAST);
        // A write in the tx_done cycle is routed to the hold register even if the line is idle.
        idle_write   = bus.tx_write && (state_q == S_IDLE) && !hold_valid_q && !done_q;

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (hold_valid_q) begin
                    load         = 1'b1;
                    hold_valid_d = 1'b0;
                end else if (idle_write) begin
                    load      = 1'b1;
                    load_byte = bus.tx_bus;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        bit_d   = 3'd0;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = 3'd0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == STOP_LAST) begin
                        done_d = 1'b1;
                        if (hold_valid_q) begin
                            load         = 1'b1;
                            hold_valid_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            bit_d   = 3'd0;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            state_d = S_START;
            baud_d  = 16'd0;
            bit_d   = 3'd0;
            shift_d = load_byte;
            par_d   = (^load_byte) ^ ODD;
        end

        if (bus.tx_write && !idle_write) begin
            if (hold_valid_q) begin
                overrun_d = 1'b1;
            end else begin
                hold_d       = bus.tx_bus;
                hold_valid_d = 1'b1;
            end
        end

        // Line level follows the next state so tx is a clean flop output.
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_q != S_IDLE) || hold_valid_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            baud_q       <= 16'd0;
            bit_q        <= 3'd0;
            shift_q      <= 8'd0;
            par_q        <= 1'b0;
            hold_q       <= 8'd0;
            hold_valid_q <= 1'b0;
            tx_q         <= 1'b1;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            tx_q         <= tx_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.tx_done    = done_q;
    assign bus.tx_busy    = busy_q;
    assign bus.tx_overrun = overrun_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - randomized self-checking bench with a frame-level reference model
module tb_uart_tx_serializer;
    localparam int N = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       wr    = 1'b0;
    logic [7:0] wbus  = 8'h00;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int lane_id, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s lane%0d: got %0h expected %0h at t=%0t", name, lane_id, act, exp, $time);
        end
    endtask

    // Line level t cycles into a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int t, input int par);
        int i;
        i = t / N;
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9 && par != 0) return (^b) ^ (par == 2);
        return 1'b1;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int PAR   = g;
        localparam int STOPS = (g == 2) ? 2 : 1;
        localparam int FLEN  = (9 + ((PAR != 0) ? 1 : 0) + STOPS) * N;

        uart_tx_serializer_if bus_if ();
        assign bus_if.tx_write = wr;
        assign bus_if.tx_bus   = wbus;

        uart_tx_serializer #(
            .CLKS_PER_BIT (N),
            .PARITY       (PAR),
            .STOP_BITS    (STOPS)
        ) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus_if.slave)
        );

        int         k = 0;
        int         s = 0;
        int         last_done = -100;
        bit         active = 1'b0;
        bit         hv = 1'b0;
        bit         ovr = 1'b0;
        logic [7:0] fb = 8'h00;
        logic [7:0] hb = 8'h00;
        logic       e_tx = 1'b1;
        logic       e_done = 1'b0;
        logic       e_busy = 1'b0;
        logic       e_ovr = 1'b0;

        always @(posedge clk or negedge reset) begin : model
            bit idle_prev;
            bit hv_prev;
            bit done_prev;
            if (!reset) begin
                active = 1'b0; hv = 1'b0; ovr = 1'b0; last_done = -100;
                e_tx = 1'b1; e_done = 1'b0; e_busy = 1'b0; e_ovr = 1'b0;
            end else begin
                k++;
                idle_prev = !active;
                hv_prev   = hv;
                done_prev = (last_done == k - 1);
                e_busy    = active || hv;
                e_done    = 1'b0;
                if (active && k == s + FLEN) begin
                    e_done    = 1'b1;
                    last_done = k;
                    if (hv) begin
                        s = k; fb = hb; hv = 1'b0;
                    end else begin
                        active = 1'b0;
                    end
                end else if (!active && hv) begin
                    active = 1'b1; s = k; fb = hb; hv = 1'b0;
                end
                if (wr) begin
                    if (idle_prev && !hv_prev && !done_prev) begin
                        active = 1'b1; s = k; fb = wbus;
                    end else if (!hv_prev) begin
                        hv = 1'b1; hb = wbus;
                    end else begin
                        ovr = 1'b1;
                    end
                end
                e_ovr = ovr;
                e_tx  = active ? frame_bit(fb, k - s, PAR) : 1'b1;
            end
        end

        always @(negedge clk) begin
            check("tx",      g, 32'(bus_if.tx),         32'(e_tx));
            check("done",    g, 32'(bus_if.tx_done),    32'(e_done));
            check("busy",    g, 32'(bus_if.tx_busy),    32'(e_busy));
            check("overrun", g, 32'(bus_if.tx_overrun), 32'(e_ovr));
        end
    end

    logic [7:0] rxq [$];
    logic [7:0] rx_b;
    logic [7:0] sent [$];
    logic [2:0] cap_tx   [0:127];
    logic [2:0] cap_done [0:127];
    int         ndone;

    // Independent mid-bit sampler on lane 0's line.
    initial begin : rx
        forever begin
            @(negedge clk);
            if (reset && lane[0].bus_if.tx === 1'b0) begin
                repeat (N / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (N) @(negedge clk);
                    rx_b[i] = lane[0].bus_if.tx;
                end
                repeat (N) @(negedge clk);
                rxq.push_back(rx_b);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr = 1'b1;
        wbus = b;
        tick();
        wr = 1'b0;
        wbus = 8'($urandom);
    endtask

    task automatic capture(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            cap_tx[c]   = {lane[2].bus_if.tx, lane[1].bus_if.tx, lane[0].bus_if.tx};
            cap_done[c] = {lane[2].bus_if.tx_done, lane[1].bus_if.tx_done, lane[0].bus_if.tx_done};
            tick();
        end
    endtask

    function automatic int first_done(input int l, input int ncyc);
        for (int c = 0; c < ncyc; c++) if (cap_done[c][l]) return c;
        return -1;
    endfunction

    task automatic check_frame(input string name, input logic [9:0] pat);
        for (int i = 0; i < 10; i++)
            check(name, 0, 32'({cap_tx[4*i][0], cap_tx[4*i+1][0], cap_tx[4*i+2][0], cap_tx[4*i+3][0]}),
                  32'({4{pat[i]}}));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        repeat (2) tick();
        while ((lane[0].bus_if.tx_busy || lane[1].bus_if.tx_busy || lane[2].bus_if.tx_busy) && n < 400) begin
            tick();
            n++;
        end
        check(name, 0, 32'(n < 400), 32'd1);
        repeat (2) tick();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int cnt;
        repeat (3) tick();
        check("rst_tx",      0, 32'(lane[0].bus_if.tx),         32'd1);
        check("rst_done",    0, 32'(lane[0].bus_if.tx_done),    32'd0);
        check("rst_busy",    0, 32'(lane[0].bus_if.tx_busy),    32'd0);
        check("rst_overrun", 0, 32'(lane[0].bus_if.tx_overrun), 32'd0);
        reset = 1'b1;
        repeat (3) tick();

        // 0x70: start, 0,0,0,0,1,1,1,0, stop
        write_byte(8'h70);
        capture(50);
        check_frame("frame_70", 10'b1011100000);
        check("len_p0", 0, 32'(first_done(0, 50)), 32'd40);
        check("len_p1", 1, 32'(first_done(1, 50)), 32'd44);
        check("len_p2", 2, 32'(first_done(2, 50)), 32'd48);
        check("busy_after", 0, 32'(lane[0].bus_if.tx_busy), 32'd0);
        wait_idle("idle_70");

        write_byte(8'h63);
        capture(50);
        check("par_even_63", 1, 32'(cap_tx[38][1]), 32'd0);
        check("par_odd_63",  2, 32'(cap_tx[38][2]), 32'd1);
        check("len_p1_63",   1, 32'(first_done(1, 50)), 32'd44);
        wait_idle("idle_63");

        rxq.delete();
        write_byte(8'hA5);
        repeat (10) tick();
        write_byte(8'h3C);
        capture(80);
        check("b2b_done1", 0, 32'(cap_done[29][0]), 32'd1);
        check("b2b_done2", 0, 32'(cap_done[69][0]), 32'd1);
        check("b2b_nogap", 0, 32'(cap_tx[29][0]), 32'd0);
        cnt = 0;
        for (int c = 0; c < 80; c++) if (cap_done[c][0]) cnt++;
        check("b2b_ndone", 0, 32'(cnt), 32'd2);
        check("b2b_ovr",   0, 32'(lane[0].bus_if.tx_overrun), 32'd0);
        wait_idle("idle_b2b");
        check("b2b_rxn", 0, 32'(rxq.size()), 32'd2);
        if (rxq.size() == 2) begin
            check("b2b_rx0", 0, 32'(rxq[0]), 32'hA5);
            check("b2b_rx1", 0, 32'(rxq[1]), 32'h3C);
        end

        rxq.delete();
        write_byte(8'h11);
        repeat (5) tick();
        write_byte(8'h22);
        repeat (5) tick();
        write_byte(8'h33);
        check("ovr_set", 0, 32'(lane[0].bus_if.tx_overrun), 32'd1);
        wait_idle("idle_ovr");
        check("ovr_sticky", 0, 32'(lane[0].bus_if.tx_overrun), 32'd1);
        check("ovr_rxn", 0, 32'(rxq.size()), 32'd2);
        if (rxq.size() == 2) begin
            check("ovr_rx0", 0, 32'(rxq[0]), 32'h11);
            check("ovr_rx1", 0, 32'(rxq[1]), 32'h22);
        end

        // 0xC3 data bit 3 is 0, so the async return to 1 is visible.
        write_byte(8'hC3);
        repeat (17) tick();
        check("pre_rst_tx", 0, 32'(lane[0].bus_if.tx), 32'd0);
        #1 reset = 1'b0;
        #1;
        check("arst_tx",   0, 32'(lane[0].bus_if.tx),      32'd1);
        check("arst_busy", 0, 32'(lane[0].bus_if.tx_busy), 32'd0);
        repeat (2) tick();
        #2 reset = 1'b1;
        check("arst_ovr_clr", 0, 32'(lane[0].bus_if.tx_overrun), 32'd0);
        repeat (50) tick();
        rxq.delete();
        write_byte(8'h55);
        capture(50);
        check_frame("frame_55", {1'b1, 8'h55, 1'b0});
        check("len_55", 0, 32'(first_done(0, 50)), 32'd40);
        wait_idle("idle_55");
        check("rx55_n", 0, 32'(rxq.size()), 32'd1);
        if (rxq.size() == 1) check("rx55", 0, 32'(rxq[0]), 32'h55);

        rxq.delete();
        sent.delete();
        ndone = 0;
        for (int i = 0; i < 203; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            write_byte(b);
            sent.push_back(b);
            n = 0;
            while (!lane[0].bus_if.tx_done && n < 100) begin
                tick();
                n++;
            end
            check("loop_done_wait", 0, 32'(n < 100), 32'd1);
            if (lane[0].bus_if.tx_done) ndone++;
        end
        wait_idle("idle_loop");
        check("loop_ndone", 0, 32'(ndone), 32'd203);
        check("loop_ovr",   0, 32'(lane[0].bus_if.tx_overrun), 32'd0);
        check("loop_rxn",   0, 32'(rxq.size()), 32'd203);
        if (rxq.size() == 203) begin
            for (int i = 0; i < 203; i++) check("loop_rx", 0, 32'(rxq[i]), 32'(sent[i]));
        end

        for (int c = 0; c < 400; c++) begin
            wr = ($urandom_range(0, 7) == 0);
            wbus = 8'($urandom);
            tick();
        end
        wr = 1'b0;
        wait_idle("idle_burst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
